mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port-write, dual-address-read memory.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dm priority.
module mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [DATA_W-1:0] mem_dpo
);

    logic              last_gnt;
    logic              pick_if;
    logic              wr;
    logic              dm_rd;
    logic [ADDR_W-1:0] a_hold;
    logic [DATA_W-1:0] d_hold;

`ifdef MEM_ARB_RR_EN
    // last_gnt == 1 means dm won last time, so fetch wins the next tie.
    assign pick_if = last_gnt;
`else
    // last_gnt is still tracked but never influences the fixed-priority tie-break.
    assign pick_if = 1'b0 & last_gnt;
`endif

    always_comb begin
        if_gnt = rst_n & if_req & (~dm_req | pick_if);
        dm_gnt = rst_n & dm_req & (~if_req | ~pick_if);
    end

    assign wr       = dm_gnt & dm_we;
    assign dm_rd    = dm_gnt & ~dm_we;
    assign mem_we   = wr;
    assign mem_dpra = dm_gnt ? dm_addr : if_addr;
    assign mem_a    = wr ? dm_addr  : a_hold;
    assign mem_d    = wr ? dm_wdata : d_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            a_hold    <= '0;
            d_hold    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if (wr) begin
                a_hold <= dm_addr;
                d_hold <= dm_wdata;
            end
            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_rdata <= mem_dpo;
            end
            dm_rvalid <= dm_rd;
            if (dm_rd) begin
                dm_rdata <= mem_dpo;
            end
            if (if_gnt | dm_gnt) begin
                last_gnt <= dm_gnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, per-scenario tasks, rdata scoreboard.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_dpra;
    logic [DATA_W-1:0] mem_dpo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] if_exp_q[$];
    int                if_cyc_q[$];
    logic [DATA_W-1:0] dm_exp_q[$];
    int                dm_cyc_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo)
    );

    function automatic logic [DATA_W-1:0] preload_val(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'h1000_0000 | 32'(a);
    endfunction

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: preload, then synchronous write, combinational read
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = preload_val(i);
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) mem[mem_a] <= mem_d;
        end
    end
    assign mem_dpo = mem[mem_dpra];

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // scoreboard: each rvalid must match the head of its port's queue, in the expected cycle
    always @(negedge clk) begin
        if (if_rvalid === 1'b1) begin
            checks++;
            if (if_exp_q.size() == 0) begin
                errors++;
                $display("FAIL if_rvalid_unexpected cyc=%0d got rdata=%h required no rvalid", cyc, if_rdata);
            end else begin
                if (if_rdata !== if_exp_q[0] || cyc != if_cyc_q[0]) begin
                    errors++;
                    $display("FAIL if_rdata cyc=%0d got %h required %h at cyc %0d", cyc, if_rdata, if_exp_q[0], if_cyc_q[0]);
                end
                void'(if_exp_q.pop_front());
                void'(if_cyc_q.pop_front());
            end
        end else if (if_cyc_q.size() > 0 && cyc >= if_cyc_q[0]) begin
            checks++;
            errors++;
            $display("FAIL if_rvalid_missing cyc=%0d got rvalid=%b required 1 data %h", cyc, if_rvalid, if_exp_q[0]);
            void'(if_exp_q.pop_front());
            void'(if_cyc_q.pop_front());
        end
        if (dm_rvalid === 1'b1) begin
            checks++;
            if (dm_exp_q.size() == 0) begin
                errors++;
                $display("FAIL dm_rvalid_unexpected cyc=%0d got rdata=%h required no rvalid", cyc, dm_rdata);
            end else begin
                if (dm_rdata !== dm_exp_q[0] || cyc != dm_cyc_q[0]) begin
                    errors++;
                    $display("FAIL dm_rdata cyc=%0d got %h required %h at cyc %0d", cyc, dm_rdata, dm_exp_q[0], dm_cyc_q[0]);
                end
                void'(dm_exp_q.pop_front());
                void'(dm_cyc_q.pop_front());
            end
        end else if (dm_cyc_q.size() > 0 && cyc >= dm_cyc_q[0]) begin
            checks++;
            errors++;
            $display("FAIL dm_rvalid_missing cyc=%0d got rvalid=%b required 1 data %h", cyc, dm_rvalid, dm_exp_q[0]);
            void'(dm_exp_q.pop_front());
            void'(dm_cyc_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input logic [DATA_W-1:0] d);
        if_exp_q.push_back(d);
        if_cyc_q.push_back(cyc + 1);
    endtask

    task automatic push_dm(input logic [DATA_W-1:0] d);
        dm_exp_q.push_back(d);
        dm_cyc_q.push_back(cyc + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got %b required 0", if_gnt); end
        checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL reset_dm_gnt got %b required 0", dm_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b required 0", mem_we); end
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid got %b required 0", if_rvalid); end
        checks++; if (dm_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dm_rvalid got %b required 0", dm_rvalid); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h required 0", if_rdata); end
        checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_dm_rdata got %h required 0", dm_rdata); end
        checks++; if (mem_a !== 11'h0 || mem_d !== 32'h0) begin errors++; $display("FAIL reset_mem_hold got a=%h d=%h required 0 0", mem_a, mem_d); end
        tick();
    endtask

    task automatic test_first_read();
        rst_n = 1'b1; if_req = 1'b1; if_addr = 11'd5;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin errors++; $display("FAIL first_read_gnt got if=%b dm=%b required 1 0", if_gnt, dm_gnt); end
        checks++; if (mem_dpra !== 11'd5 || mem_we !== 1'b0) begin errors++; $display("FAIL first_read_mem got dpra=%h we=%b required 5 0", mem_dpra, mem_we); end
        push_if(32'hDEADBEEF);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_write_read();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h7FF; dm_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got dm=%b if=%b required 1 0", dm_gnt, if_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_a !== 11'h7FF || mem_d !== 32'h12345678) begin errors++; $display("FAIL wr_mem got we=%b a=%h d=%h required 1 7ff 12345678", mem_we, mem_a, mem_d); end
        tick();
        dm_we = 1'b0; dm_wdata = 32'h0;
        @(negedge clk);
        checks++; if (dm_gnt !== 1'b1 || mem_we !== 1'b0 || mem_dpra !== 11'h7FF) begin errors++; $display("FAIL rd_after_wr got gnt=%b we=%b dpra=%h required 1 0 7ff", dm_gnt, mem_we, mem_dpra); end
        checks++; if (mem_a !== 11'h7FF || mem_d !== 32'h12345678) begin errors++; $display("FAIL mem_hold got a=%h d=%h required 7ff 12345678", mem_a, mem_d); end
        push_dm(32'h12345678);
        tick();
        dm_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_arbitration();
        logic exp_if;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 11'd1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2 == 0);
`else
            exp_if = 1'b0;
`endif
            checks++;
            if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin
                errors++;
                $display("FAIL arb_cycle%0d got if=%b dm=%b required if=%b dm=%b", k, if_gnt, dm_gnt, exp_if, !exp_if);
            end
            if (exp_if) push_if(preload_val(1));
            else push_dm(preload_val(2));
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset_after_grant();
        if_req = 1'b1; if_addr = 11'd5;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rag_gnt got %b required 1", if_gnt); end
        push_if(32'hDEADBEEF);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rag_gnt_in_reset got %b required 0", if_gnt); end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rag_cleared got rvalid=%b rdata=%h required 0 0", if_rvalid, if_rdata); end
        tick();
    endtask

    task automatic test_write_in_reset();
        rst_n = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'd3; dm_wdata = 32'hBAD0BAD0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || dm_gnt !== 1'b0) begin
                errors++;
                $display("FAIL wir_cycle%0d got mem_we=%b dm_gnt=%b required 0 0", k, mem_we, dm_gnt);
            end
            tick();
        end
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        checks++; if (mem[3] !== preload_val(3)) begin errors++; $display("FAIL wir_mem got %h required %h", mem[3], preload_val(3)); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        if_req = 1'b1;
        for (int a = 0; a < 3; a++) begin
            if_addr = ADDR_W'(a);
            @(negedge clk);
            checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b required 1", a, if_gnt); end
            push_if(preload_val(a));
            tick();
        end
        if_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        logic exp_last, pend_if, pend_dm, exp_if, exp_dm;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_last = 1'b1; pend_if = 1'b0; pend_dm = 1'b0;
        dm_we = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!pend_if) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = ADDR_W'($urandom_range(0, 7));
                pend_if = if_req;
            end
            if (!pend_dm) begin
                dm_req = 1'($urandom_range(0, 1));
                dm_addr = ADDR_W'($urandom_range(0, 7));
                pend_dm = dm_req;
            end
`ifdef MEM_ARB_RR_EN
            exp_if = pend_if && (!pend_dm || exp_last);
`else
            exp_if = pend_if && !pend_dm;
`endif
            exp_dm = pend_dm && !exp_if;
            @(negedge clk);
            checks++;
            if (if_gnt !== exp_if || dm_gnt !== exp_dm) begin
                errors++;
                $display("FAIL rand_cycle%0d got if=%b dm=%b required if=%b dm=%b", k, if_gnt, dm_gnt, exp_if, exp_dm);
            end
            if (exp_if) begin push_if(preload_val(int'(if_addr))); pend_if = 1'b0; exp_last = 1'b0; end
            if (exp_dm) begin push_dm(preload_val(int'(dm_addr))); pend_dm = 1'b0; exp_last = 1'b1; end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read();
        test_arbitration();
        test_reset_after_grant();
        test_write_in_reset();
        test_back_to_back();
        test_random();
        checks++;
        if (if_exp_q.size() != 0 || dm_exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got if_pending=%0d dm_pending=%0d required 0 0", if_exp_q.size(), dm_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
